bp_be_scoreboard_port_sched: RTL
================================

# bp_be_scoreboard_port_sched

Sequences all scoreboard update traffic in the dual-issue backend onto the scoreboard's single score port and single clear port. It takes two in-order dispatch lanes that may both request a score in the same cycle and serializes them over two cycles. It round-robin arbitrates `num_clr_p` writeback/completion sources (long-latency FP, D$ miss fill, etc.) into a small clear FIFO that drains one clear per cycle. It sits between the issue/dispatch logic and `bp_be_scoreboard`.

## Interface
- Clocking: one clock; reset is synchronous and active-high.
- `bp_params_p`, default `e_bp_default_cfg`: processor config; supplies `reg_addr_width_gp`.
- `num_clr_p`, default 3: number of clear requesters; must be ≥1.
- `clr_fifo_els_p`, default 4: clear FIFO depth; power of two, ≥2.
- `clk_i`  in  1  clock.
- `reset_i`  in  1  synchronous active-high reset.
- `score_v_i`  in  2  per-lane score request; lane 0 is older.
- `score_rd_i`  in  2×`reg_addr_width_gp`  per-lane destination register.
- `score_ready_o`  out  2  per-lane acceptance; the handshake is `v & ready`.
- `clr_v_i`  in  `num_clr_p`  clear request valid.
- `clr_rd_i`  in  `num_clr_p`×`reg_addr_width_gp`  register to clear.
- `clr_ready_o`  out  `num_clr_p`  one-hot-or-zero grant.
- `score_v_o`  out  1  to scoreboard `score_v_i`.
- `score_rd_o`  out  `reg_addr_width_gp`  to scoreboard `score_rd_i`.
- `clear_v_o`  out  1  to scoreboard `clear_v_i`.
- `clear_rd_o`  out  `reg_addr_width_gp`  to scoreboard `clear_rd_i`.
- `clr_pending_o`  out  `$clog2(clr_fifo_els_p+1)`  FIFO occupancy.
- `busy_o`  out  1  high when the FSM is not IDLE or the FIFO is non-empty.

## Operation
Score FSM, states IDLE and SECOND.
- **IDLE**
  - `score_ready_o = 2'b11`.
  - Exactly one lane valid: that lane's rd is driven on `score_v_o`/`score_rd_o` combinationally in the same cycle. Stay in IDLE.
  - Both lanes valid: drive lane 0's rd. Capture lane 1's rd into `held_rd_r`. Go to SECOND. Both lanes are accepted this cycle.
- **SECOND**
  - `score_ready_o = 2'b00`.
  - Drive `score_v_o=1` with `score_rd_o = held_rd_r`.
  - Return to IDLE next cycle unconditionally.
- Equal rd on both lanes is still scored twice; this is harmless.

Clear path.
- Round-robin arbiter over `clr_v_i`, starting at pointer `rr_r`.
  - Grant goes to the first valid index at or after `rr_r`, wrapping modulo `num_clr_p`.
  - `clr_ready_o[g]` = grant & ~full.
  - On a handshake, `rr_r <= (g+1) mod num_clr_p`. Otherwise `rr_r` holds.
- FIFO order:
  - Enqueue at most one clear per cycle.
  - Dequeue one clear per cycle whenever non-empty: `clear_v_o = ~empty`, `clear_rd_o = head`.
  - Simultaneous enqueue and dequeue when full is not allowed; ready is low when full.
  - Simultaneous enqueue and dequeue at any other occupancy keeps the occupancy unchanged.
- Pointers are `$clog2(clr_fifo_els_p)` bits and wrap naturally. Full/empty are tracked by the occupancy counter.
- A score and a clear to the same rd in one cycle are both presented; the scoreboard gives set priority.

## Timing
- Reset values:
  - FSM = IDLE; FIFO empty; `rr_r=0`; `held_rd_r=0`.
  - `score_ready_o=0` and `clr_ready_o=0` while `reset_i` is high.
  - `score_v_o=0`, `clear_v_o=0`, `clr_pending_o=0`, `busy_o=0`.
- Score latency: 0 cycles for a single lane and for lane 0 of a pair; +1 cycle for lane 1 of a pair.
- Clear latency: 1 cycle from handshake to `clear_v_o` when the FIFO is empty; otherwise ordered behind earlier entries.
- Reset asserted in SECOND drops the held score. Reset asserted with a non-empty FIFO discards all entries.
- Sustained throughput: 1 score/cycle, or 2 scores per 2 cycles when paired; 1 clear/cycle.

## Configuration
- `BP_BE_SCORE_SCHED_CLR_BYPASS_EN`
  - **Defined:** when the FIFO is empty and a clear handshake occurs, the clear is driven on `clear_v_o`/`clear_rd_o` in the same cycle and is not enqueued. Clear latency is 0.
  - **Undefined:** every clear goes through the FIFO. Clear latency is ≥1.
  - Occupancy, ordering and ready rules are otherwise identical in both builds.

## Test plan
- Lane 0 only, rd=5 → same cycle `score_v_o=1`, `score_rd_o=5`; `score_ready_o=11`; FSM stays IDLE.
- Both lanes valid, rd 3/7 → cycle N scores 3; cycle N+1 scores 7 with `score_ready_o=00`; cycle N+2 is back in IDLE with `score_ready_o=11`.
- All 3 clear sources valid continuously, rd 1/2/3, `rr_r=0` → grants 0,1,2,0 on consecutive cycles; `clear_rd_o` sequence 1,2,3,1 starting one cycle later (bypass undefined).
- Clear the FIFO is filling while drain is blocked? Not applicable; instead, 4 back-to-back clears in the bypass build with the FIFO empty → each appears in the same cycle and `clr_pending_o` stays 0.
- Assert `reset_i` in SECOND with 2 FIFO entries → next cycle `score_v_o=0`, `clear_v_o=0`, `clr_pending_o=0`, `busy_o=0`, `rr_r=0`.
- Score rd=9 and clear rd=9 in the same cycle (bypass build) → both `score_v_o` and `clear_v_o` are high; the scoreboard bit for rd 9 reads set the next cycle.

Source files
------------

// File: rtl/bp_be_scoreboard_port_sched_if.sv
// Bundle of the scoreboard update traffic around bp_be_scoreboard_port_sched.
// The master side is the dispatch lanes, the clear sources and the scoreboard together.
// The slave side is the scheduler.
interface bp_be_scoreboard_port_sched_if
    #(parameter int num_clr_p         = 3
    , parameter int reg_addr_width_gp = 5
    , parameter int clr_fifo_els_p    = 4
    );

    localparam int pending_width_lp = $clog2(clr_fifo_els_p + 1);

    logic [1:0]                                  score_v_i;
    logic [1:0][reg_addr_width_gp-1:0]           score_rd_i;
    logic [1:0]                                  score_ready_o;
    logic [num_clr_p-1:0]                        clr_v_i;
    logic [num_clr_p-1:0][reg_addr_width_gp-1:0] clr_rd_i;
    logic [num_clr_p-1:0]                        clr_ready_o;
    logic                                        score_v_o;
    logic [reg_addr_width_gp-1:0]                score_rd_o;
    logic                                        clear_v_o;
    logic [reg_addr_width_gp-1:0]                clear_rd_o;
    logic [pending_width_lp-1:0]                 clr_pending_o;
    logic                                        busy_o;

    modport master (
        output score_v_i, score_rd_i, clr_v_i, clr_rd_i,
        input  score_ready_o, clr_ready_o, score_v_o, score_rd_o,
               clear_v_o, clear_rd_o, clr_pending_o, busy_o
    );

    modport slave (
        input  score_v_i, score_rd_i, clr_v_i, clr_rd_i,
        output score_ready_o, clr_ready_o, score_v_o, score_rd_o,
               clear_v_o, clear_rd_o, clr_pending_o, busy_o
    );

endinterface

// File: rtl/bp_be_scoreboard_port_sched.sv
// bp_be_scoreboard_port_sched: funnels two dispatch score lanes and num_clr_p
// completion sources onto the scoreboard's single score port and single clear port.
// A paired score is split over two cycles.
// Clears are round-robin arbitrated into a small FIFO that drains one entry per cycle.
// reg_addr_width_gp stands in for the register address width of the processor config.
// Optional feature macro: BP_BE_SCORE_SCHED_CLR_BYPASS_EN.
// When it is defined, a clear that arrives while the FIFO is empty skips the FIFO
// and is presented in the same cycle.
module bp_be_scoreboard_port_sched
    #(parameter int num_clr_p         = 3
    , parameter int reg_addr_width_gp = 5
    , parameter int clr_fifo_els_p    = 4
    )
    (input  logic clk_i
    , input logic reset_i
    , bp_be_scoreboard_port_sched_if.slave bus
    );

    localparam int rr_width_lp      = (num_clr_p > 1) ? $clog2(num_clr_p) : 1;
    localparam int ptr_width_lp     = $clog2(clr_fifo_els_p);
    localparam int pending_width_lp = $clog2(clr_fifo_els_p + 1);

    typedef enum logic {e_idle, e_second} state_e;

    state_e                       state_r;
    logic [reg_addr_width_gp-1:0] held_rd_r;

    logic [1:0]                   score_ready;
    logic [1:0]                   score_fire;
    logic                         score_v;
    logic [reg_addr_width_gp-1:0] score_rd;

    logic [rr_width_lp-1:0]       rr_r;
    logic [rr_width_lp-1:0]       rr_next;
    logic                         grant_found;
    logic [rr_width_lp-1:0]       grant_idx;
    logic [reg_addr_width_gp-1:0] grant_rd;
    logic [num_clr_p-1:0]         clr_ready;
    logic                         clr_fire;
    logic                         bypass;
    logic                         enq;
    logic                         deq;

    logic [clr_fifo_els_p-1:0][reg_addr_width_gp-1:0] mem_r;
    logic [ptr_width_lp-1:0]      wr_ptr_r;
    logic [ptr_width_lp-1:0]      rd_ptr_r;
    logic [pending_width_lp-1:0]  count_r;
    logic                         empty;
    logic                         full;

    assign empty = (count_r == '0);
    assign full  = (count_r == pending_width_lp'(clr_fifo_els_p));

    // Score port: pass a single lane or lane 0 straight through, replay the held lane 1 in SECOND.
    always_comb begin
        score_ready = 2'b00;
        score_v     = 1'b0;
        score_rd    = '0;
        if (!reset_i && state_r == e_idle)
            score_ready = 2'b11;
        score_fire = bus.score_v_i & score_ready;
        if (!reset_i) begin
            if (state_r == e_second) begin
                score_v  = 1'b1;
                score_rd = held_rd_r;
            end else if (score_fire[0]) begin
                score_v  = 1'b1;
                score_rd = bus.score_rd_i[0];
            end else if (score_fire[1]) begin
                score_v  = 1'b1;
                score_rd = bus.score_rd_i[1];
            end
        end
    end

    // Score FSM: a pair parks lane 1 for one cycle, and SECOND always returns to IDLE.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r   <= e_idle;
            held_rd_r <= '0;
        end else begin
            case (state_r)
                e_idle: begin
                    if (&score_fire) begin
                        state_r   <= e_second;
                        held_rd_r <= bus.score_rd_i[1];
                    end
                end
                default: state_r <= e_idle;
            endcase
        end
    end

    // Round-robin search: first valid source at or after rr_r, wrapping around.
    always_comb begin
        int idx;
        grant_found = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        for (int i = 0; i < num_clr_p; i++) begin
            idx = (int'(rr_r) + i) % num_clr_p;
            if (!grant_found && bus.clr_v_i[idx]) begin
                grant_found = 1'b1;
                grant_idx   = rr_width_lp'(idx);
            end
        end
    end

    assign grant_rd = bus.clr_rd_i[grant_idx];
    assign clr_fire = grant_found & ~full & ~reset_i;
    assign rr_next  = (grant_idx == rr_width_lp'(num_clr_p - 1)) ? '0
                                                                 : grant_idx + rr_width_lp'(1);

`ifdef BP_BE_SCORE_SCHED_CLR_BYPASS_EN
    assign bypass = clr_fire & empty;
`else
    assign bypass = 1'b0;
`endif

    assign enq = clr_fire & ~bypass;
    assign deq = ~empty & ~reset_i;

    // One-hot grant to the winning source, suppressed when the FIFO cannot take it.
    always_comb begin
        clr_ready = '0;
        if (clr_fire)
            clr_ready[grant_idx] = 1'b1;
    end

    // FIFO storage: entries need no reset because the occupancy count marks them stale.
    always_ff @(posedge clk_i) begin
        if (enq)
            mem_r[wr_ptr_r] <= grant_rd;
    end

    // FIFO pointers, occupancy and arbiter pointer; reset discards every queued clear.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            rr_r     <= '0;
        end else begin
            if (enq)
                wr_ptr_r <= wr_ptr_r + ptr_width_lp'(1);
            if (deq)
                rd_ptr_r <= rd_ptr_r + ptr_width_lp'(1);
            case ({enq, deq})
                2'b10:   count_r <= count_r + pending_width_lp'(1);
                2'b01:   count_r <= count_r - pending_width_lp'(1);
                default: count_r <= count_r;
            endcase
            if (clr_fire)
                rr_r <= rr_next;
        end
    end

    assign bus.score_ready_o = score_ready;
    assign bus.score_v_o     = score_v;
    assign bus.score_rd_o    = score_rd;
    assign bus.clr_ready_o   = clr_ready;
    assign bus.clear_v_o     = ~reset_i & (~empty | bypass);
    assign bus.clear_rd_o    = empty ? grant_rd : mem_r[rd_ptr_r];
    assign bus.clr_pending_o = count_r;
    assign bus.busy_o        = ~reset_i & ((state_r != e_idle) | ~empty);

endmodule
